// File: rtl/controle_servo_rampa.sv
// controle_servo_rampa: angle command to slew-limited PWM pulse width.
// Optional macro SERVO_RAMPA_EN enables PASSO-limited stepping; undefined jumps on one tick.
module controle_servo_rampa #(
    parameter int N       = 50000,
    parameter int ANG_MAX = 180,
    parameter int PASSO   = 500,
    parameter int PERIODO = 1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           posicao,
    input  logic                 carrega,
    output logic [$clog2(N)-1:0] largura,
    output logic                 em_movimento,
    output logic                 pronto,
    output logic                 erro_faixa
);

    localparam int W  = $clog2(N);
    localparam int WS = W + 1;
    localparam int PW = 8 + WS;
    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;

    localparam logic [7:0]    AMAX  = 8'(ANG_MAX);
    localparam logic [CW-1:0] ULT   = CW'(PERIODO - 1);
    localparam logic [PW-1:0] N_PW  = PW'(N);
    localparam logic [PW-1:0] A_PW  = PW'(ANG_MAX);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        ESPERA
    } estado_t;

    estado_t estado;
    estado_t estado_prox;

    logic [CW-1:0] contador;
    logic          tick;

    logic [7:0]    p_reg;
    logic [PW-1:0] produto;
    logic [W-1:0]  alvo;
    logic [W-1:0]  alvo_calc;
    logic [W-1:0]  alvo_prox;
    logic [W-1:0]  largura_prox;
    logic [W-1:0]  largura_passo;
    logic          pronto_prox;

    logic          subindo;
    logic [WS-1:0] dif;
    logic [WS-1:0] passo_lim;
    logic [WS-1:0] delta;

    assign tick = (contador == ULT);

    // Free-running period counter; tick marks the last clock of each PWM period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador <= '0;
        end else if (tick) begin
            contador <= '0;
        end else begin
            contador <= contador + CW'(1);
        end
    end

    // Capture the clamped angle and the range flag on every load strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_reg      <= '0;
            erro_faixa <= 1'b0;
        end else if (carrega) begin
            p_reg      <= (posicao > AMAX) ? AMAX : posicao;
            erro_faixa <= (posicao > AMAX);
        end
    end

    // Target width: full-width product then division by the full-scale angle.
    always_comb begin
        produto   = PW'(p_reg) * N_PW;
        alvo_calc = W'(produto / A_PW);
    end

    // One slew step toward alvo, clipped so it never passes the target.
    always_comb begin
        subindo = (alvo > largura);
        if (subindo) begin
            dif = WS'(alvo) - WS'(largura);
        end else begin
            dif = WS'(largura) - WS'(alvo);
        end
`ifdef SERVO_RAMPA_EN
        passo_lim = WS'(PASSO);
`else
        passo_lim = dif;
`endif
        delta = (dif < passo_lim) ? dif : passo_lim;
        if (subindo) begin
            largura_passo = W'(WS'(largura) + delta);
        end else begin
            largura_passo = W'(WS'(largura) - delta);
        end
    end

    // Next state, next target/width and the completion pulse.
    always_comb begin
        estado_prox  = estado;
        alvo_prox    = alvo;
        largura_prox = largura;
        pronto_prox  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (carrega) begin
                    estado_prox = CALCULA;
                end
            end
            CALCULA: begin
                alvo_prox = alvo_calc;
                if (carrega) begin
                    estado_prox = CALCULA;
                end else if (alvo_calc == largura) begin
                    pronto_prox = 1'b1;
                    estado_prox = OCIOSO;
                end else begin
                    estado_prox = ESPERA;
                end
            end
            ESPERA: begin
                if (tick) begin
                    largura_prox = largura_passo;
                end
                if (carrega) begin
                    estado_prox = CALCULA;
                end else if (tick && (largura_passo == alvo)) begin
                    pronto_prox = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // State, target, width and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            alvo         <= '0;
            largura      <= '0;
            pronto       <= 1'b0;
            em_movimento <= 1'b0;
        end else begin
            estado       <= estado_prox;
            alvo         <= alvo_prox;
            largura      <= largura_prox;
            pronto       <= pronto_prox;
            em_movimento <= (estado_prox != OCIOSO) &&
                            (alvo_prox != largura_prox);
        end
    end

endmodule

// File: tb/tb_controle_servo_rampa.sv
// tb_controle_servo_rampa: randomized scoreboard bench for controle_servo_rampa.
// Reference model follows the ramp rules per period; monitor checks width/pronto events.
module tb_controle_servo_rampa;

    localparam int N       = 1800;
    localparam int ANG_MAX = 180;
    localparam int PASSO   = 100;
    localparam int PERIODO = 20;
    localparam int W       = $clog2(N);
`ifdef SERVO_RAMPA_EN
    localparam int LIMITE = PASSO;
`else
    localparam int LIMITE = N + 1;
`endif

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic         carrega = 1'b0;
    logic [7:0]   posicao = 8'd0;
    logic [W-1:0] largura;
    logic         em_movimento;
    logic         pronto;
    logic         erro_faixa;

    controle_servo_rampa #(
        .N       (N),
        .ANG_MAX (ANG_MAX),
        .PASSO   (PASSO),
        .PERIODO (PERIODO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .posicao      (posicao),
        .carrega      (carrega),
        .largura      (largura),
        .em_movimento (em_movimento),
        .pronto       (pronto),
        .erro_faixa   (erro_faixa)
    );

    always #5 clock = ~clock;

    typedef struct {
        int larg;
        int pr;
    } evento_t;

    int      checks = 0;
    int      errors = 0;
    evento_t fila[$];
    bit      mon_en = 1'b0;

    // Reference model: position within the period, width, target, pending load.
    int fase   = 0;
    int m_larg = 0;
    int m_alvo = 0;
    int m_p    = 0;
    bit m_calc = 1'b0;
    bit m_ramp = 1'b0;
    bit m_erro = 1'b0;

    task automatic chk(input string nome, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    // Monitor: every width change or pronto pulse must match the next expected event.
    initial begin
        int      ultimo;
        evento_t e;
        ultimo = 0;
        forever begin
            @(negedge clock);
            if (mon_en && ((int'(largura) != ultimo) || pronto)) begin
                if (fila.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evento_inesperado: largura %0d pronto %0b, none expected at %0t",
                             largura, pronto, $time);
                end else begin
                    e = fila.pop_front();
                    chk("evento_largura", int'(largura), e.larg);
                    chk("evento_pronto", int'(pronto), e.pr);
                end
            end
            ultimo = int'(largura);
        end
    end

    // One clock of stimulus; the model predicts what this cycle's edge produces.
    task automatic ciclo(input bit c, input int p);
        bit      tick;
        int      d;
        int      s;
        evento_t e;
        @(negedge clock);
        chk("em_movimento", int'(em_movimento),
            int'((m_calc || m_ramp) && (m_alvo != m_larg)));
        chk("erro_faixa", int'(erro_faixa), int'(m_erro));
        carrega = c;
        posicao = 8'(p);
        tick = (fase == PERIODO - 1);
        if (m_calc) begin
            m_calc = 1'b0;
            m_alvo = (m_p * N) / ANG_MAX;
            if (m_alvo == m_larg) begin
                e.larg = m_larg;
                e.pr   = 1;
                fila.push_back(e);
                m_ramp = 1'b0;
            end else begin
                m_ramp = 1'b1;
            end
        end else if (tick && m_ramp) begin
            d = m_alvo - m_larg;
            s = (d < 0) ? -d : d;
            if (s > LIMITE) s = LIMITE;
            m_larg = (d < 0) ? m_larg - s : m_larg + s;
            e.larg = m_larg;
            e.pr   = (m_larg == m_alvo && !c) ? 1 : 0;
            fila.push_back(e);
            if (e.pr == 1) m_ramp = 1'b0;
        end
        if (c) begin
            m_calc = 1'b1;
            m_ramp = 1'b0;
            m_p    = (p > ANG_MAX) ? ANG_MAX : p;
            m_erro = (p > ANG_MAX);
        end
        fase = (fase + 1) % PERIODO;
    endtask

    task automatic comando(input int p);
        ciclo(1'b1, p);
    endtask

    task automatic espera(input int n);
        repeat (n) ciclo(1'b0, 0);
    endtask

    // Advance so that the next ciclo call lands on a tick cycle.
    task automatic ate_tick();
        while (fase != PERIODO - 1) ciclo(1'b0, 0);
    endtask

    task automatic assenta();
        espera(PERIODO * 20);
        chk("largura_assentada", int'(largura), m_larg);
        chk("fila_vazia", fila.size(), 0);
    endtask

    task automatic aplica_reset();
        mon_en = 1'b0;
        #2;
        reset   = 1'b0;
        carrega = 1'b0;
        #1;
        chk("reset_largura", int'(largura), 0);
        chk("reset_em_movimento", int'(em_movimento), 0);
        chk("reset_erro_faixa", int'(erro_faixa), 0);
        chk("reset_pronto", int'(pronto), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        fila.delete();
        m_larg = 0;
        m_alvo = 0;
        m_p    = 0;
        m_calc = 1'b0;
        m_ramp = 1'b0;
        m_erro = 1'b0;
        fase   = 1;
        mon_en = 1'b1;
    endtask

    initial begin
        int p;
        aplica_reset();

        comando(90);
        assenta();

        comando(200);
        assenta();
        comando(0);
        assenta();

        comando(90);
        assenta();
        comando(95);
        assenta();

        comando(0);
        assenta();
        comando(90);
        ciclo(1'b0, 0);
        repeat (4) begin
            ate_tick();
            ciclo(1'b0, 0);
        end
        comando(30);
        assenta();

        comando(0);
        assenta();
        comando(90);
        ciclo(1'b0, 0);
        ciclo(1'b0, 0);
        ate_tick();
        ciclo(1'b1, 30);
        assenta();

        comando(180);
        espera(45);
        aplica_reset();
        comando(45);
        assenta();

        for (int i = 0; i < 25; i++) begin
            espera($urandom_range(1, PERIODO * 10));
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(181, 255);
            end else begin
                p = $urandom_range(0, 180);
            end
            comando(p);
        end
        assenta();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_servo_rampa.md
Name: controle_servo_rampa

Overview:
- Upstream stage of the servo PWM generator: converts an angle command into the `largura` pulse-width word that the PWM block latches once per period.
- Slews the width toward the target in bounded steps, one update per PWM period, so the servo never sees step jumps.
- Reports motion status back to the system FSM.

Parameters:
- N, 50000, full-scale width in clocks; `largura` range is 0..N, port width is $clog2(N).
- ANG_MAX, 180, angle code that maps to width N.
- PASSO, 500, maximum width change per update, in clocks.
- PERIODO, 1000000, clocks between updates; equals the PWM period.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- posicao, input, 8: commanded angle code, 0..ANG_MAX.
- carrega, input, 1: one-cycle strobe; samples posicao.
- largura, output, $clog2(N): current pulse-width word to the PWM stage.
- em_movimento, output, 1: high while largura != alvo.
- pronto, output, 1: one-cycle pulse when largura reaches alvo.
- erro_faixa, output, 1: sticky flag; set on an out-of-range command.

Behaviour:
- Reset (reset=0, asynchronous):
  - largura=0, alvo=0, contador=0, state OCIOSO.
  - em_movimento=0, pronto=0, erro_faixa=0.
  - Deassertion is taken synchronously on the next clock edge.
- Tick counter:
  - Free-running contador 0..PERIODO-1; wraps to 0.
  - tick is high in the cycle where contador==PERIODO-1.
  - Runs in every state. Never reset by carrega.
- Target calculation:
  - On carrega: p = min(posicao, ANG_MAX).
  - alvo = floor(p*N/ANG_MAX), using a full-width intermediate product, no overflow.
  - alvo is registered 1 cycle after carrega (state CALCULA).
- erro_faixa:
  - Set on a carrega with posicao > ANG_MAX.
  - Cleared by the next carrega with an in-range posicao.
- FSM states: OCIOSO, CALCULA, ESPERA.
  - OCIOSO: carrega -> CALCULA.
  - CALCULA (1 cycle): load alvo. If alvo==largura, pulse pronto and go to OCIOSO; else go to ESPERA.
  - ESPERA: on tick, largura moves toward alvo by min(PASSO, |alvo-largura|).
  - ESPERA: if the new largura==alvo, pronto=1 in the following cycle and go to OCIOSO.
- carrega while in ESPERA (retarget):
  - Go to CALCULA. The ramp continues from the current largura; no reset of largura.
  - Motion direction may reverse.
- carrega and tick in the same cycle: the tick step uses the old alvo; the new alvo loads next cycle.
- tick in CALCULA: that update is skipped; the next tick applies.
- em_movimento = (state != OCIOSO) && (alvo != largura); registered.
- largura changes only on tick, so the PWM stage never sees more than one change per period.
- Arithmetic:
  - Unsigned throughout.
  - Step computed on $clog2(N)+1 bits; no underflow below 0, no overshoot above N.

Optional Feature:
- Macro SERVO_RAMPA_EN.
- Defined: slew-limited stepping as described above.
- Undefined:
  - PASSO is ignored; on the first tick in ESPERA, largura=alvo.
  - pronto pulses the next cycle.
  - em_movimento is high only from CALCULA until that tick.

Test Plan:
- Bench parameters: N=1800, ANG_MAX=180, PASSO=100, PERIODO=20.
- Reset, then hold reset=0 mid-ramp -> largura=0, em_movimento=0 and erro_faixa=0 immediately (asynchronous); contador restarts at 0.
- posicao=90 with carrega from largura=0 -> alvo=900; largura steps 100,200..900 on 9 consecutive ticks; pronto pulses once, 1 cycle after the 9th tick.
- posicao=200 -> erro_faixa=1; alvo=1800 (clamped); ramp to 1800. Then posicao=0 -> erro_faixa clears; largura ramps down in 100-count steps to 0.
- From largura=900, posicao=95 -> alvo=950; 1 tick, step 50 (partial step), then pronto.
- Retarget: ramping 0->900, at largura=400 send posicao=30 (alvo=300) -> next tick largura=300, pronto; no overshoot.
- carrega asserted on the tick cycle -> that tick steps toward the old alvo; new alvo used from the next tick. Repeat with SERVO_RAMPA_EN undefined -> largura jumps 0->900 on a single tick.
